// File: rtl/axil_pipe_pkg.sv
// Shared types and constants for the AXI4-Lite pipeline slice.
package axil_pipe_pkg;

  typedef enum logic {FULL = 1'b0, LIGHT = 1'b1} mode_e;

  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_B  = 2;
  localparam int CH_AR = 3;
  localparam int CH_R  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_pipe_stage.sv
// One valid/ready register stage with an opaque payload: skid buffer (FULL)
// or single half-rate register (LIGHT).
module axil_pipe_stage
  import axil_pipe_pkg::*;
#(
  parameter int    WIDTH = 8,
  parameter mode_e MODE  = FULL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_v;
  logic [WIDTH-1:0] main_d;
  logic             in_fire;
  logic             out_fire;

  // Valid is masked during reset so no beat leaves in the reset cycle.
  assign out_valid = main_v && !reset;
  assign out_data  = main_d;
  assign out_fire  = out_valid && out_ready;
  assign in_fire   = in_valid && in_ready;

  if (MODE == FULL) begin : g_full
    logic             skid_v;
    logic [WIDTH-1:0] skid_d;

    assign in_ready = !skid_v && !reset;

    always_ff @(posedge clock) begin
      if (reset) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (out_fire || !main_v) begin
        // skid_v implies main_v, and no input is accepted while skid_v is set
        if (skid_v) begin
          main_d <= skid_d;
          skid_v <= 1'b0;
        end else begin
          main_v <= in_fire;
          if (in_fire) main_d <= in_data;
        end
      end else if (in_fire) begin
        skid_v <= 1'b1;
        skid_d <= in_data;
      end
    end
  end else begin : g_light
    assign in_ready = !main_v && !reset;

    always_ff @(posedge clock) begin
      if (reset) begin
        main_v <= 1'b0;
      end else if (out_fire) begin
        main_v <= 1'b0;
      end else if (in_fire) begin
        main_v <= 1'b1;
        main_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/axil_pipe_slice.sv
// AXI4-Lite pipeline slice: STAGES register stages on each channel selected
// by CH_MASK; unselected channels are plain wires.
module axil_pipe_slice
  import axil_pipe_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          STAGES  = 1,
  parameter mode_e       MODE    = FULL,
  parameter logic [4:0]  CH_MASK = 5'h1F
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic [2:0]            s_arprot,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arprot,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp
);

  localparam int AX_PW = ADDR_W + 3;
  localparam int W_PW  = DATA_W + DATA_W / 8;
  localparam int R_PW  = DATA_W + 2;

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("axil_pipe_slice: DATA_W must be 32 or 64");
  end
  if (STAGES < 0 || STAGES > 4) begin : g_bad_stages
    $error("axil_pipe_slice: STAGES must be 0..4");
  end

  if (CH_MASK[CH_AW] && STAGES > 0) begin : g_aw
    logic             v [STAGES+1];
    logic             r [STAGES+1];
    logic [AX_PW-1:0] d [STAGES+1];
    assign v[0] = s_awvalid;
    assign d[0] = {s_awaddr, s_awprot};
    assign s_awready = r[0];
    assign m_awvalid = v[STAGES];
    assign {m_awaddr, m_awprot} = d[STAGES];
    assign r[STAGES] = m_awready;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      axil_pipe_stage #(.WIDTH(AX_PW), .MODE(MODE)) u_stage (
        .clock(clock), .reset(reset),
        .in_valid(v[i]), .in_ready(r[i]), .in_data(d[i]),
        .out_valid(v[i+1]), .out_ready(r[i+1]), .out_data(d[i+1]));
    end
  end else begin : g_aw_wire
    assign m_awvalid = s_awvalid;
    assign s_awready = m_awready;
    assign m_awaddr  = s_awaddr;
    assign m_awprot  = s_awprot;
  end

  if (CH_MASK[CH_W] && STAGES > 0) begin : g_w
    logic            v [STAGES+1];
    logic            r [STAGES+1];
    logic [W_PW-1:0] d [STAGES+1];
    assign v[0] = s_wvalid;
    assign d[0] = {s_wdata, s_wstrb};
    assign s_wready = r[0];
    assign m_wvalid = v[STAGES];
    assign {m_wdata, m_wstrb} = d[STAGES];
    assign r[STAGES] = m_wready;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      axil_pipe_stage #(.WIDTH(W_PW), .MODE(MODE)) u_stage (
        .clock(clock), .reset(reset),
        .in_valid(v[i]), .in_ready(r[i]), .in_data(d[i]),
        .out_valid(v[i+1]), .out_ready(r[i+1]), .out_data(d[i+1]));
    end
  end else begin : g_w_wire
    assign m_wvalid = s_wvalid;
    assign s_wready = m_wready;
    assign m_wdata  = s_wdata;
    assign m_wstrb  = s_wstrb;
  end

  // B and R flow from the master side back to the slave side.
  if (CH_MASK[CH_B] && STAGES > 0) begin : g_b
    logic       v [STAGES+1];
    logic       r [STAGES+1];
    logic [1:0] d [STAGES+1];
    assign v[0] = m_bvalid;
    assign d[0] = m_bresp;
    assign m_bready = r[0];
    assign s_bvalid = v[STAGES];
    assign s_bresp  = d[STAGES];
    assign r[STAGES] = s_bready;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      axil_pipe_stage #(.WIDTH(2), .MODE(MODE)) u_stage (
        .clock(clock), .reset(reset),
        .in_valid(v[i]), .in_ready(r[i]), .in_data(d[i]),
        .out_valid(v[i+1]), .out_ready(r[i+1]), .out_data(d[i+1]));
    end
  end else begin : g_b_wire
    assign s_bvalid = m_bvalid;
    assign m_bready = s_bready;
    assign s_bresp  = m_bresp;
  end

  if (CH_MASK[CH_AR] && STAGES > 0) begin : g_ar
    logic             v [STAGES+1];
    logic             r [STAGES+1];
    logic [AX_PW-1:0] d [STAGES+1];
    assign v[0] = s_arvalid;
    assign d[0] = {s_araddr, s_arprot};
    assign s_arready = r[0];
    assign m_arvalid = v[STAGES];
    assign {m_araddr, m_arprot} = d[STAGES];
    assign r[STAGES] = m_arready;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      axil_pipe_stage #(.WIDTH(AX_PW), .MODE(MODE)) u_stage (
        .clock(clock), .reset(reset),
        .in_valid(v[i]), .in_ready(r[i]), .in_data(d[i]),
        .out_valid(v[i+1]), .out_ready(r[i+1]), .out_data(d[i+1]));
    end
  end else begin : g_ar_wire
    assign m_arvalid = s_arvalid;
    assign s_arready = m_arready;
    assign m_araddr  = s_araddr;
    assign m_arprot  = s_arprot;
  end

  if (CH_MASK[CH_R] && STAGES > 0) begin : g_r
    logic            v [STAGES+1];
    logic            r [STAGES+1];
    logic [R_PW-1:0] d [STAGES+1];
    assign v[0] = m_rvalid;
    assign d[0] = {m_rdata, m_rresp};
    assign m_rready = r[0];
    assign s_rvalid = v[STAGES];
    assign {s_rdata, s_rresp} = d[STAGES];
    assign r[STAGES] = s_rready;
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      axil_pipe_stage #(.WIDTH(R_PW), .MODE(MODE)) u_stage (
        .clock(clock), .reset(reset),
        .in_valid(v[i]), .in_ready(r[i]), .in_data(d[i]),
        .out_valid(v[i+1]), .out_ready(r[i+1]), .out_data(d[i+1]));
    end
  end else begin : g_r_wire
    assign s_rvalid = m_rvalid;
    assign m_rready = s_rready;
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
  end

endmodule

// File: tb/tb_axil_pipe_slice.sv
// Bench: FULL/2-stage slice under a per-channel FIFO scoreboard, plus a
// LIGHT/1-stage slice with AW/W as wires for the directed checks.
module tb_axil_pipe_slice;
  import axil_pipe_pkg::*;

  localparam int N_BEATS = 1000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          cycle = 0;
  always @(posedge clock) cycle++;

  // Generic per-channel view of the main DUT: src = upstream side, dst = downstream side.
  logic        src_valid [5];
  logic [35:0] src_data  [5];
  logic        dst_ready [5];
  logic        src_ready [5];
  logic        dst_valid [5];
  logic [35:0] dst_data  [5];

  logic        s_awvalid, s_awready, m_awvalid, m_awready;
  logic [31:0] s_awaddr, m_awaddr;
  logic [2:0]  s_awprot, m_awprot;
  logic        s_wvalid, s_wready, m_wvalid, m_wready;
  logic [31:0] s_wdata, m_wdata;
  logic [3:0]  s_wstrb, m_wstrb;
  logic        s_bvalid, s_bready, m_bvalid, m_bready;
  logic [1:0]  s_bresp, m_bresp;
  logic        s_arvalid, s_arready, m_arvalid, m_arready;
  logic [31:0] s_araddr, m_araddr;
  logic [2:0]  s_arprot, m_arprot;
  logic        s_rvalid, s_rready, m_rvalid, m_rready;
  logic [31:0] s_rdata, m_rdata;
  logic [1:0]  s_rresp, m_rresp;

  assign s_awvalid = src_valid[CH_AW];
  assign {s_awaddr, s_awprot} = src_data[CH_AW][34:0];
  assign m_awready = dst_ready[CH_AW];
  assign s_wvalid = src_valid[CH_W];
  assign {s_wdata, s_wstrb} = src_data[CH_W];
  assign m_wready = dst_ready[CH_W];
  assign m_bvalid = src_valid[CH_B];
  assign m_bresp  = src_data[CH_B][1:0];
  assign s_bready = dst_ready[CH_B];
  assign s_arvalid = src_valid[CH_AR];
  assign {s_araddr, s_arprot} = src_data[CH_AR][34:0];
  assign m_arready = dst_ready[CH_AR];
  assign m_rvalid = src_valid[CH_R];
  assign {m_rdata, m_rresp} = src_data[CH_R][33:0];
  assign s_rready = dst_ready[CH_R];

  always_comb begin
    src_ready = '{s_awready, s_wready, m_bready, s_arready, m_rready};
    dst_valid = '{m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid};
    dst_data  = '{{1'b0, m_awaddr, m_awprot}, {m_wdata, m_wstrb}, {34'b0, s_bresp},
                  {1'b0, m_araddr, m_arprot}, {2'b0, s_rdata, s_rresp}};
  end

  axil_pipe_slice #(.ADDR_W(32), .DATA_W(32), .STAGES(2), .MODE(FULL), .CH_MASK(5'h1F)) u_full (
    .clock(clock), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp));

  // LIGHT slice, 64-bit data, AW/W unregistered.
  logic        l_s_awvalid = 0, l_s_awready, l_m_awvalid, l_m_awready = 0;
  logic [31:0] l_s_awaddr = '0, l_m_awaddr;
  logic [2:0]  l_s_awprot = '0, l_m_awprot;
  logic        l_s_wvalid = 0, l_s_wready, l_m_wvalid, l_m_wready = 0;
  logic [63:0] l_s_wdata = '0, l_m_wdata;
  logic [7:0]  l_s_wstrb = '0, l_m_wstrb;
  logic        l_s_bvalid, l_s_bready = 0, l_m_bvalid = 0, l_m_bready;
  logic [1:0]  l_s_bresp, l_m_bresp = '0;
  logic        l_s_arvalid = 0, l_s_arready, l_m_arvalid, l_m_arready = 0;
  logic [31:0] l_s_araddr = '0, l_m_araddr;
  logic [2:0]  l_s_arprot = '0, l_m_arprot;
  logic        l_s_rvalid, l_s_rready = 0, l_m_rvalid = 0, l_m_rready;
  logic [63:0] l_s_rdata, l_m_rdata = '0;
  logic [1:0]  l_s_rresp, l_m_rresp = '0;

  axil_pipe_slice #(.ADDR_W(32), .DATA_W(64), .STAGES(1), .MODE(LIGHT), .CH_MASK(5'b11100)) u_light (
    .clock(clock), .reset(reset),
    .s_awvalid(l_s_awvalid), .s_awready(l_s_awready), .s_awaddr(l_s_awaddr), .s_awprot(l_s_awprot),
    .s_wvalid(l_s_wvalid), .s_wready(l_s_wready), .s_wdata(l_s_wdata), .s_wstrb(l_s_wstrb),
    .s_bvalid(l_s_bvalid), .s_bready(l_s_bready), .s_bresp(l_s_bresp),
    .s_arvalid(l_s_arvalid), .s_arready(l_s_arready), .s_araddr(l_s_araddr), .s_arprot(l_s_arprot),
    .s_rvalid(l_s_rvalid), .s_rready(l_s_rready), .s_rdata(l_s_rdata), .s_rresp(l_s_rresp),
    .m_awvalid(l_m_awvalid), .m_awready(l_m_awready), .m_awaddr(l_m_awaddr), .m_awprot(l_m_awprot),
    .m_wvalid(l_m_wvalid), .m_wready(l_m_wready), .m_wdata(l_m_wdata), .m_wstrb(l_m_wstrb),
    .m_bvalid(l_m_bvalid), .m_bready(l_m_bready), .m_bresp(l_m_bresp),
    .m_arvalid(l_m_arvalid), .m_arready(l_m_arready), .m_araddr(l_m_araddr), .m_arprot(l_m_arprot),
    .m_rvalid(l_m_rvalid), .m_rready(l_m_rready), .m_rdata(l_m_rdata), .m_rresp(l_m_rresp));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [35:0] ch_mask(input int ch);
    case (ch)
      CH_AW, CH_AR: return 36'h7_FFFF_FFFF;
      CH_W:         return '1;
      CH_B:         return 36'h0_0000_0003;
      default:      return 36'h3_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [35:0] rand_payload(input int ch);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[35:0] & ch_mask(ch);
  endfunction

  function automatic logic [35:0] w_beat(input int k);
    return {32'hA1 + 32'(k), 4'hF - 4'(k)};
  endfunction

  // Reference model: each channel is a lossless FIFO; a reset empties it.
  logic [35:0] sb [5][$];
  logic        prev_stall [5];
  logic [35:0] prev_data  [5];
  int          aw_in_cyc [$];
  int          aw_out_cyc [$];

  always @(negedge clock) begin : monitor
    logic [35:0] exp_d;
    for (int ch = 0; ch < 5; ch++) begin
      if (reset) begin
        sb[ch].delete();
        prev_stall[ch] = 1'b0;
      end else begin
        if (prev_stall[ch]) begin
          tests++;
          if (!dst_valid[ch] || dst_data[ch] !== prev_data[ch]) begin
            fails++;
            $display("FAIL hold ch%0d: valid=%0b data=%h, required valid=1 data=%h",
                     ch, dst_valid[ch], dst_data[ch], prev_data[ch]);
          end
        end
        if (src_valid[ch] && src_ready[ch]) begin
          sb[ch].push_back(src_data[ch]);
          if (ch == CH_AW) aw_in_cyc.push_back(cycle);
        end
        if (dst_valid[ch] && dst_ready[ch]) begin
          tests++;
          if (sb[ch].size() == 0) begin
            fails++;
            $display("FAIL order ch%0d: got %h, required no beat (model empty)", ch, dst_data[ch]);
          end else begin
            exp_d = sb[ch].pop_front();
            if (dst_data[ch] !== exp_d) begin
              fails++;
              $display("FAIL order ch%0d: got %h, required %h", ch, dst_data[ch], exp_d);
            end
          end
          if (ch == CH_AW) aw_out_cyc.push_back(cycle);
        end
        prev_stall[ch] = dst_valid[ch] && !dst_ready[ch];
        prev_data[ch]  = dst_data[ch];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  k;
    int  issued [5];
    bit  fire [5];
    bit  done;
    int  highs, same, rgot, rsent;
    bit  prev_rv, in_f;

    for (int ch = 0; ch < 5; ch++) begin
      src_valid[ch] = 1'b0;
      src_data[ch]  = '0;
      dst_ready[ch] = 1'b0;
    end

    // Reset held with an AW beat offered.
    src_valid[CH_AW] = 1'b1;
    src_data[CH_AW]  = 36'h0_0000_02A9;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("reset m_awvalid", dst_valid[CH_AW], 0);
      check("reset s_awready", src_ready[CH_AW], 0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    dst_ready[CH_AW] = 1'b1;
    @(negedge clock);
    check("post-reset s_awready", src_ready[CH_AW], 1);
    @(posedge clock); #1;
    src_valid[CH_AW] = 1'b0;
    repeat (6) @(posedge clock);
    #1;

    // Throughput: 16 back-to-back AW beats.
    aw_in_cyc.delete();
    aw_out_cyc.delete();
    k = 0;
    src_valid[CH_AW] = 1'b1;
    src_data[CH_AW]  = '0;
    for (int c = 0; c < 40 && k < 16; c++) begin
      @(negedge clock);
      if (src_ready[CH_AW]) k++;
      @(posedge clock); #1;
      if (k == 16) src_valid[CH_AW] = 1'b0;
      else src_data[CH_AW] = 36'(k) << 3;
    end
    repeat (6) @(posedge clock);
    #1;
    check("tput in beats", aw_in_cyc.size(), 16);
    check("tput out beats", aw_out_cyc.size(), 16);
    if (aw_in_cyc.size() == 16 && aw_out_cyc.size() == 16) begin
      check("tput latency", aw_out_cyc[0] - aw_in_cyc[0], 2);
      check("tput in span", aw_in_cyc[15] - aw_in_cyc[0], 15);
      check("tput out span", aw_out_cyc[15] - aw_out_cyc[0], 15);
    end

    // Backpressure on W: capacity of two FULL stages is four beats.
    k = 0;
    src_valid[CH_W] = 1'b1;
    src_data[CH_W]  = w_beat(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (src_ready[CH_W]) k++;
      @(posedge clock); #1;
      src_data[CH_W] = w_beat(k);
    end
    @(negedge clock);
    check("bp accepted", k, 4);
    check("bp s_wready low", src_ready[CH_W], 0);
    check("bp m_wvalid held", dst_valid[CH_W], 1);
    @(posedge clock); #1;
    dst_ready[CH_W] = 1'b1;
    @(negedge clock);
    check("bp first out", dst_data[CH_W], w_beat(0));
    for (int c = 0; c < 20 && k < 5; c++) begin
      if (src_ready[CH_W]) k++;
      @(posedge clock); #1;
      if (k == 5) src_valid[CH_W] = 1'b0;
      else src_data[CH_W] = w_beat(k);
      @(negedge clock);
    end
    check("bp all accepted", k, 5);
    repeat (6) @(posedge clock);
    #1;

    // Randomised traffic on all channels with a reset mid-stream.
    for (int ch = 0; ch < 5; ch++) issued[ch] = 0;
    for (int it = 0; it < 20000; it++) begin
      done = 1'b1;
      for (int ch = 0; ch < 5; ch++) if (issued[ch] < N_BEATS) done = 1'b0;
      if (done) break;
      @(negedge clock);
      for (int ch = 0; ch < 5; ch++) fire[ch] = src_valid[ch] && src_ready[ch] && !reset;
      @(posedge clock); #1;
      for (int ch = 0; ch < 5; ch++) begin
        if (fire[ch]) begin
          issued[ch]++;
          src_valid[ch] = 1'b0;
        end
        if (!src_valid[ch] && issued[ch] < N_BEATS && $urandom_range(0, 3) != 0) begin
          src_valid[ch] = 1'b1;
          src_data[ch]  = rand_payload(ch);
        end
        dst_ready[ch] = ($urandom_range(0, 2) != 0);
      end
      reset = (it >= 700 && it < 703);
    end
    reset = 1'b0;
    for (int ch = 0; ch < 5; ch++) begin
      check($sformatf("rand issued ch%0d", ch), issued[ch], N_BEATS);
      src_valid[ch] = 1'b0;
      dst_ready[ch] = 1'b1;
    end
    for (int c = 0; c < 50; c++) begin
      @(posedge clock);
      done = 1'b1;
      for (int ch = 0; ch < 5; ch++) if (sb[ch].size() != 0) done = 1'b0;
      if (done) break;
    end
    @(negedge clock);
    for (int ch = 0; ch < 5; ch++)
      check($sformatf("rand drained ch%0d", ch), sb[ch].size(), 0);

    // LIGHT slice: AW/W are combinational wires.
    @(posedge clock); #1;
    l_s_awvalid = 1'b1; l_s_awaddr = 32'hDEAD_BEE0; l_s_awprot = 3'h5; l_m_awready = 1'b1;
    l_s_wvalid = 1'b1; l_s_wdata = 64'h0123_4567_89AB_CDEF; l_s_wstrb = 8'h5A; l_m_wready = 1'b0;
    #1;
    check("wire m_awvalid", l_m_awvalid, 1);
    check("wire m_awaddr", l_m_awaddr, 32'hDEAD_BEE0);
    check("wire m_awprot", l_m_awprot, 3'h5);
    check("wire s_awready", l_s_awready, 1);
    check("wire m_wvalid", l_m_wvalid, 1);
    check("wire m_wdata", l_m_wdata, 64'h0123_4567_89AB_CDEF);
    check("wire m_wstrb", l_m_wstrb, 8'h5A);
    check("wire s_wready", l_s_wready, 0);
    @(posedge clock); #1;
    l_s_awvalid = 1'b0; l_s_wvalid = 1'b0; l_m_awready = 1'b0;

    // LIGHT slice: AR registered, one cycle of latency.
    l_s_arvalid = 1'b1; l_s_araddr = 32'h0000_1234; l_s_arprot = 3'h2; l_m_arready = 1'b1;
    @(negedge clock);
    check("light ar s_arready", l_s_arready, 1);
    check("light ar not same cycle", l_m_arvalid, 0);
    @(posedge clock); #1;
    l_s_arvalid = 1'b0;
    @(negedge clock);
    check("light ar m_arvalid", l_m_arvalid, 1);
    check("light ar m_araddr", l_m_araddr, 32'h0000_1234);
    check("light ar m_arprot", l_m_arprot, 3'h2);

    // LIGHT slice: continuous R beats emerge every other cycle, SLVERR intact.
    @(posedge clock); #1;
    l_m_arready = 1'b0;
    l_s_rready = 1'b1; l_m_rvalid = 1'b1; l_m_rresp = RESP_SLVERR; l_m_rdata = '0;
    rsent = 0; rgot = 0; highs = 0; same = 0; prev_rv = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      in_f = l_m_rvalid && l_m_rready;
      if (l_s_rvalid) begin
        highs++;
        check("light rdata", l_s_rdata, 64'(rgot));
        check("light rresp", l_s_rresp, RESP_SLVERR);
        rgot++;
      end
      if (c > 0 && l_s_rvalid == prev_rv) same++;
      prev_rv = l_s_rvalid;
      @(posedge clock); #1;
      if (in_f) begin
        rsent++;
        l_m_rdata = 64'(rsent);
      end
    end
    l_m_rvalid = 1'b0;
    check("light r beats", highs, 6);
    check("light r alternating", same, 0);

    repeat (4) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
